// File: rtl/router_pkg.sv
// Shared types and constants for the router destination-side read scheduler.
package router_pkg;

  localparam int NUM_DEST    = 3;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int BEAT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ABORT
  } sched_state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
    logic                   err;
    logic [1:0]             src;
  } beat_t;

  // Round-robin pick: first requesting port after 'last', wrapping mod NUM_DEST.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [NUM_DEST-1:0] req);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int k = NUM_DEST; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % NUM_DEST);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry beat buffer; head is forced to zero while empty so idle outputs read as 0.
module router_skid_buf #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign head = (cnt != 2'd0) ? mem[rd_ptr] : '0;
  assign occ  = cnt;

endmodule

// File: rtl/router_read_sched.sv
// Round-robin read scheduler draining one whole packet at a time from three
// destination FIFOs into a single framed stream with parity check and stall abort.
//
// state  | meaning
// IDLE   | no packet owned; grant next valid port round-robin
// ACTIVE | reading granted port until byte number 'total' is captured
// ABORT  | granted port stalled too long; emit one error eop beat
module router_read_sched
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STALL_MAX = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_out_0,
  input  logic              valid_out_1,
  input  logic              valid_out_2,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic [1:0]        m_src,
  output logic              m_err
);

  localparam int TW = $clog2(STALL_MAX + 1);
  localparam int BW = DATA_W + 5;

  sched_state_e        state, state_nx;
  logic [1:0]          grant, last_grant;
  logic [6:0]          issued, rx_cnt, total, limit, hdr_total;
  logic                hdr_seen, inflight;
  logic [DATA_W-1:0]   parity, cap_data;
  logic [TW-1:0]       stall_tmr;
  logic [NUM_DEST-1:0] vo;
  logic                vo_g, space, first, last, stalling;
  logic                rd_en, push, pop, end_pkt;
  logic [BW-1:0]       push_data, head;
  logic [1:0]          occ;

  assign vo = {valid_out_2, valid_out_1, valid_out_0};

  always_comb begin
    vo_g     = 1'b0;
    cap_data = '0;
    case (grant)
      2'd0:    begin vo_g = valid_out_0; cap_data = data_out_0; end
      2'd1:    begin vo_g = valid_out_1; cap_data = data_out_1; end
      2'd2:    begin vo_g = valid_out_2; cap_data = data_out_2; end
      default: ;
    endcase
  end

  assign pop       = m_valid && m_ready;
  assign space     = (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
  assign limit     = hdr_seen ? total : 7'd2;
  assign hdr_total = 7'(cap_data[LEN_MSB:LEN_LSB]) + 7'd2;
  assign first     = (rx_cnt == 7'd0);
  assign last      = inflight && !first && ((rx_cnt + 7'd1) == total);
  // Stall only counts while nothing is in flight and the packet is unfinished.
  assign stalling  = !vo_g && !inflight && (issued < limit);

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    end_pkt   = 1'b0;
    case (state)
      IDLE: begin
        if (|vo) state_nx = ACTIVE;
      end
      ACTIVE: begin
        rd_en = space && vo_g && (issued < limit);
        if (inflight) begin
          push      = 1'b1;
          push_data = {cap_data, first, last, last && (parity != cap_data), grant};
        end
        if (last) begin
          state_nx = IDLE;
          end_pkt  = 1'b1;
        end else if (stalling && stall_tmr == TW'(1)) begin
          state_nx = ABORT;
        end
      end
      ABORT: begin
        if (space) begin
          push      = 1'b1;
          push_data = {{DATA_W{1'b0}}, 1'b0, 1'b1, 1'b1, grant};
          state_nx  = IDLE;
          end_pkt   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd2;
      issued     <= 7'd0;
      rx_cnt     <= 7'd0;
      total      <= 7'd0;
      hdr_seen   <= 1'b0;
      inflight   <= 1'b0;
      parity     <= '0;
      stall_tmr  <= TW'(STALL_MAX);
    end else begin
      state    <= state_nx;
      inflight <= rd_en;
      if (rd_en) issued <= issued + 7'd1;
      if (end_pkt) last_grant <= grant;
      case (state)
        IDLE: begin
          if (|vo) begin
            grant     <= rr_pick(last_grant, vo);
            issued    <= 7'd0;
            rx_cnt    <= 7'd0;
            hdr_seen  <= 1'b0;
            stall_tmr <= TW'(STALL_MAX);
          end
        end
        ACTIVE: begin
          if (inflight) begin
            rx_cnt <= rx_cnt + 7'd1;
            if (first) begin
              total    <= hdr_total;
              hdr_seen <= 1'b1;
              parity   <= cap_data;
            end else begin
              parity <= parity ^ cap_data;
            end
          end
          if (!stalling)                stall_tmr <= TW'(STALL_MAX);
          else if (stall_tmr != TW'(1)) stall_tmr <= stall_tmr - TW'(1);
        end
        default: ;
      endcase
    end
  end

  router_skid_buf #(.W(BW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign {m_data, m_sop, m_eop, m_err, m_src} = head;

  assign read_enb_0 = rd_en && (grant == 2'd0);
  assign read_enb_1 = rd_en && (grant == 2'd1);
  assign read_enb_2 = rd_en && (grant == 2'd2);

endmodule

// File: tb/tb_router_read_sched.sv
// Scoreboard bench: source FIFO models feed the scheduler, expected beats are queued at send time.
module tb_router_read_sched;
  import router_pkg::*;

  localparam int DATA_W    = 8;
  localparam int STALL_MAX = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid_out_0 = 1'b0, valid_out_1 = 1'b0, valid_out_2 = 1'b0;
  logic [DATA_W-1:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
  logic              read_enb_0, read_enb_1, read_enb_2;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_sop, m_eop, m_err;
  logic              m_ready = 1'b1;
  logic [1:0]        m_src;

  always #5 clk = ~clk;

  router_read_sched #(.DATA_W(DATA_W), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .reset(reset),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .m_src(m_src), .m_err(m_err)
  );

  logic [7:0] q0[$], q1[$], q2[$];
  beat_t      exp_q[$];
  int         checks = 0, errors = 0, cyc = 0;
  logic [2:0] rd_s = 3'b000;
  int         rd_cnt0 = 0;
  int         ready_mode = 0;
  bit         credit_chk = 1'b0;
  int         cr_reads = 0, cr_pops = 0;
  int         abort_seen = 0, abort_gap = 0, prev_acc = 0;
  int         last_sop_cyc = 0, last_eop_cyc = 0;
  int         tb_last_g = 2;

  // Source FIFOs: a read strobed in cycle N presents data in cycle N+1.
  always @(posedge clk) begin
    cyc++;
    if (rd_s[0]) begin if (q0.size() > 0) data_out_0 <= q0.pop_front(); else data_out_0 <= 8'h00; end
    if (rd_s[1]) begin if (q1.size() > 0) data_out_1 <= q1.pop_front(); else data_out_1 <= 8'h00; end
    if (rd_s[2]) begin if (q2.size() > 0) data_out_2 <= q2.pop_front(); else data_out_2 <= 8'h00; end
    #2;
    valid_out_0 = (q0.size() != 0);
    valid_out_1 = (q1.size() != 0);
    valid_out_2 = (q2.size() != 0);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       m_ready = ((cyc % 3) == 0);
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b1;
    endcase
  end

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    beat_t got, e;
    bit    popped;
    rd_s   = {read_enb_2, read_enb_1, read_enb_0};
    popped = m_valid && m_ready;
    if (rd_s != 3'b000) begin
      checks++;
      if (!$onehot(rd_s)) begin
        errors++;
        $display("FAIL read_onehot got=%b required one-hot", rd_s);
      end
    end
    if (rd_s[0]) rd_cnt0++;
    if (!credit_chk) begin
      cr_reads = 0;
      cr_pops  = 0;
    end else begin
      if (rd_s != 3'b000) begin
        checks++;
        if (cr_reads - cr_pops - int'(popped) >= 2) begin
          errors++;
          $display("FAIL credit occ+inflight-pop=%0d required <2", cr_reads - cr_pops - int'(popped));
        end
      end
      cr_reads += int'(rd_s != 3'b000);
      cr_pops  += int'(popped);
    end
    if (popped) begin
      got.data = m_data; got.sop = m_sop; got.eop = m_eop; got.err = m_err; got.src = m_src;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got=%h required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL beat got={d=%h s=%b e=%b err=%b src=%0d} required={d=%h s=%b e=%b err=%b src=%0d}",
                   got.data, got.sop, got.eop, got.err, got.src, e.data, e.sop, e.eop, e.err, e.src);
        end
      end
      if (got.sop) last_sop_cyc = cyc;
      if (got.eop) last_eop_cyc = cyc;
      if (got.eop && got.err && !got.sop && got.data == 8'h00) begin
        abort_seen++;
        abort_gap = cyc - prev_acc;
      end
      prev_acc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_src(input int port, input logic [7:0] b);
    case (port)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Packet model: header, length payload bytes, XOR parity; cut>=0 delivers only
  // that many bytes, after which an abort beat is expected.
  task automatic send_bytes(input int port, input logic [7:0] hdr, input int cut,
                            input bit bad, input bit fixed);
    logic [7:0] pkt[$];
    logic [7:0] par, b;
    beat_t      e;
    int         len, n;
    len = int'(hdr[7:2]);
    pkt.push_back(hdr);
    par = hdr;
    for (int k = 0; k < len; k++) begin
      b = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
      pkt.push_back(b);
      par ^= b;
    end
    pkt.push_back(bad ? ~par : par);
    n = (cut < 0) ? pkt.size() : cut;
    for (int k = 0; k < n; k++) begin
      push_src(port, pkt[k]);
      e.data = pkt[k];
      e.sop  = (k == 0);
      e.eop  = (k == pkt.size() - 1);
      e.err  = bad && e.eop;
      e.src  = 2'(port);
      exp_q.push_back(e);
    end
    if (cut >= 0) begin
      e.data = 8'h00; e.sop = 1'b0; e.eop = 1'b1; e.err = 1'b1; e.src = 2'(port);
      exp_q.push_back(e);
    end
    tb_last_g = port;
  endtask

  // Ports loaded together are served round-robin starting after the last served port.
  task automatic send_group(input logic [2:0] mask, input bit rnd);
    int start, p;
    start = tb_last_g;
    for (int k = 1; k <= 3; k++) begin
      p = (start + k) % 3;
      if (mask[p]) begin
        if (rnd) send_bytes(p, {6'($urandom_range(0, 12)), 2'($urandom)}, -1, ($urandom_range(0, 3) == 0), 1'b0);
        else     send_bytes(p, 8'h00, -1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic flush_all();
    exp_q.delete();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain got=%0d beats pending after %0d cycles required 0", name, exp_q.size(), n);
      flush_all();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    logic [16:0] v;
    v = {m_valid, m_sop, m_eop, m_err, m_src, m_data, read_enb_0, read_enb_1, read_enb_2};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s outputs got=%h required 0", name, v);
    end
  endtask

  initial begin
    int base_rd, base_ab, port;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    tick();
    reset = 1'b0;

    // Round-robin order from reset: 0,1,2 then 0,2.
    send_group(3'b111, 1'b0);
    drain("rr_all", 200);
    send_group(3'b101, 1'b0);
    drain("rr_02", 200);

    // Header 0C with payload 11 22 33 on port 0, full rate.
    base_rd = rd_cnt0;
    send_bytes(0, 8'h0C, -1, 1'b0, 1'b1);
    drain("pkt0", 200);
    checks++;
    if (rd_cnt0 - base_rd != 5) begin
      errors++;
      $display("FAIL read_count0 got=%0d required 5", rd_cnt0 - base_rd);
    end
    checks++;
    if (last_eop_cyc - last_sop_cyc != 4) begin
      errors++;
      $display("FAIL throughput sop-to-eop got=%0d cycles required 4", last_eop_cyc - last_sop_cyc);
    end

    // Backpressure pattern on a length-2 packet from port 1.
    credit_chk = 1'b1;
    ready_mode = 1;
    send_bytes(1, 8'h08, -1, 1'b0, 1'b0);
    drain("backpressure", 300);
    credit_chk = 1'b0;
    ready_mode = 0;

    // Corrupted parity on port 2, then a clean packet from the same port.
    send_bytes(2, 8'h0E, -1, 1'b1, 1'b0);
    drain("bad_parity", 200);
    send_bytes(2, 8'h06, -1, 1'b0, 1'b0);
    drain("after_bad", 200);

    // Port 0 stalls after header plus two payload bytes; port 1 waits behind it.
    base_ab = abort_seen;
    send_bytes(0, 8'h10, 3, 1'b0, 1'b0);
    repeat (3) tick();
    send_bytes(1, 8'h04, -1, 1'b0, 1'b0);
    drain("abort", 500);
    checks++;
    if (abort_seen - base_ab != 1) begin
      errors++;
      $display("FAIL abort_count got=%0d required 1", abort_seen - base_ab);
    end
    checks++;
    if (abort_gap < STALL_MAX || abort_gap > STALL_MAX + 3) begin
      errors++;
      $display("FAIL abort_delay got=%0d required %0d..%0d", abort_gap, STALL_MAX, STALL_MAX + 3);
    end

    // Reset in the middle of a payload.
    send_bytes(0, {6'd20, 2'b01}, -1, 1'b0, 1'b0);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    flush_all();
    @(negedge clk);
    check_zero("reset_mid");
    tick();
    reset = 1'b0;
    tb_last_g = 2;
    send_bytes(0, 8'h0D, -1, 1'b0, 1'b0);
    drain("after_reset", 200);

    // Randomized traffic with random backpressure.
    ready_mode = 2;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_group(3'($urandom_range(1, 7)), 1'b1);
      end else begin
        port = $urandom_range(0, 2);
        send_bytes(port, 8'($urandom_range(0, 255)), -1, ($urandom_range(0, 3) == 0), 1'b0);
      end
      drain("random", 3000);
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
